status_value_pull_ctrl: RTL and testbench
=========================================

Name: status_value_pull_ctrl

Overview:
Consumer-side controller for the status value vector. It watches the vector head (entry [0]) and issues single-cycle pull strobes to pop entries. Each popped entry is presented on a registered valid/ready output stage. A flush mode drains the vector without presenting the entries and counts how many were discarded.

Parameters:
WIDTH, 1, bit width of each status value entry
DROP_W, 8, width of the saturating discard counter

Ports:
clk_i  input  1  system clock, rising edge
arstn_i  input  1  asynchronous active-low reset
enable_i  input  1  level; 1 = deliver entries, 0 = hold (no new pulls)
flush_i  input  1  single-cycle request to discard all entries in the vector
head_valid_i  input  1  valid mask bit [0] of the vector (head occupied)
head_value_i  input  WIDTH  status value at vector entry [0]
pull_o  output  1  pull strobe to the vector; pops the head at the clock edge
data_o  output  WIDTH  presented entry
valid_o  output  1  data_o valid
ready_i  input  1  downstream accepts data_o when valid_o & ready_i
busy_o  output  1  1 while in S_FLUSH
flush_done_o  output  1  one-cycle pulse when a flush completes
drop_cnt_o  output  DROP_W  saturating count of discarded entries (last flush)
pull_cnt_o  output  16  delivered-entry count (see Optional Feature)

Behaviour:
- Clock and reset: one clock, clk_i. Reset arstn_i is asynchronous, active-low.
- Reset values: state=S_IDLE; valid_o=0; data_o=0; flush_done_o=0; drop_cnt_o=0; pull_cnt_o=0; busy_o=0. pull_o is 0 while in reset.
- Output stage: one register. It can accept a new entry when it is free: free = ~valid_o | ready_i.
- pull_o is combinational:
  - S_RUN: pull_o = head_valid_i & free.
  - S_FLUSH: pull_o = head_valid_i.
  - S_IDLE: pull_o = 0.
- Latency: head_value_i is sampled at the edge where pull_o=1. It appears on data_o with valid_o=1 in the next cycle.
- Throughput: 1 entry/cycle when the head stays valid and ready_i stays high.
- Handshake rules:
  - Once valid_o=1, data_o is held stable until valid_o & ready_i.
  - valid_o falls after a transfer only if no new pull happens in the same cycle.
  - A pull and a transfer in the same cycle replace data_o back-to-back.
- FSM states: S_IDLE, S_RUN, S_FLUSH.
  - S_IDLE -> S_RUN when enable_i=1.
  - S_RUN -> S_IDLE when enable_i=0. Any entry already in the output stage is still delivered.
  - S_IDLE or S_RUN -> S_FLUSH on flush_i=1. flush_i has priority over enable_i.
  - S_FLUSH -> S_IDLE in the first cycle with head_valid_i=0. flush_done_o pulses in that cycle.
- Flush rules:
  - On entry to S_FLUSH, drop_cnt_o clears to 0.
  - Each pull in S_FLUSH adds 1 to drop_cnt_o, saturating at 2^DROP_W-1.
  - Flushed entries never reach data_o.
  - An entry already presented (valid_o=1) is kept and delivered normally.
  - flush_i while already in S_FLUSH is ignored; the counter is not cleared.
- Empty flush: flush_i with head_valid_i=0 enters S_FLUSH for one cycle. flush_done_o pulses with drop_cnt_o=0, then the FSM returns to S_IDLE.
- Empty vector in S_RUN: no pull is issued; the state is unchanged.
- The vector head may refill in the same cycle as a pull; this block only acts on the sampled head_valid_i.
- Reset mid-operation: everything returns to reset values asynchronously; any presented entry is lost.

Optional Feature:
- Macro: STATUS_VALUE_PULL_CNT_EN.
- Defined: pull_cnt_o increments by 1 on each valid_o & ready_i transfer. It is 16-bit, wraps 0xFFFF -> 0x0000, and is not cleared by a flush.
- Not defined: no counter register; pull_cnt_o is tied to 0.

Test Plan:
- Reset with head_valid_i=1, value 0x1 held: pull_o=0, valid_o=0, drop_cnt_o=0 until enable_i=1. One cycle after enable_i=1, pull_o=1.
- S_RUN, ready_i=1, head values 1,0,1,1 on consecutive cycles: data_o=1,0,1,1 one cycle after each pull; 4 pulls in 4 cycles.
- ready_i=0 with valid_o=1, head valid: pull_o=0 and data_o held stable for 5 cycles. ready_i=1: transfer and pull occur in the same cycle.
- Vector holds 6 entries, flush_i pulse: 6 consecutive pull_o cycles, valid_o stays 0, then flush_done_o=1 with drop_cnt_o=6 and state S_IDLE.
- DROP_W=2, 5-entry flush: drop_cnt_o saturates at 3. Empty flush: flush_done_o pulses one cycle after flush_i with drop_cnt_o=0.
- arstn_i low during S_FLUSH: outputs return to reset values immediately. With STATUS_VALUE_PULL_CNT_EN defined, 3 transfers give pull_cnt_o=3; without it, pull_cnt_o=0.

Source files
------------

// File: rtl/status_value_pull_ctrl.sv
// status_value_pull_ctrl
//
// Consumer-side controller for the status value vector. It watches the vector
// head (entry [0]) and issues single-cycle pull strobes to pop entries. Popped
// entries go to a registered valid/ready output stage. Flush mode drains the
// vector without presenting entries and counts how many were discarded.
//
// Optional feature macro: STATUS_VALUE_PULL_CNT_EN
//   defined   : pull_cnt_o counts valid_o & ready_i transfers (16-bit, wraps,
//               not cleared by a flush)
//   undefined : pull_cnt_o is tied to 0
//
// Ports:
//   clk_i         system clock, rising edge
//   arstn_i       asynchronous active-low reset
//   enable_i      1 = deliver entries, 0 = hold (no new pulls)
//   flush_i       single-cycle request to discard all vector entries
//   head_valid_i  head of vector occupied
//   head_value_i  value at vector entry [0]
//   pull_o        pull strobe; pops the head at the clock edge
//   data_o        presented entry
//   valid_o       data_o valid
//   ready_i       downstream accepts data_o when valid_o & ready_i
//   busy_o        1 while flushing
//   flush_done_o  one-cycle pulse when a flush completes
//   drop_cnt_o    saturating count of entries discarded by the last flush
//   pull_cnt_o    delivered-entry count (optional feature)

module status_value_pull_ctrl #(
  parameter int unsigned WIDTH  = 1,
  parameter int unsigned DROP_W = 8
) (
  input  logic              clk_i,
  input  logic              arstn_i,
  input  logic              enable_i,
  input  logic              flush_i,
  input  logic              head_valid_i,
  input  logic [WIDTH-1:0]  head_value_i,
  output logic              pull_o,
  output logic [WIDTH-1:0]  data_o,
  output logic              valid_o,
  input  logic              ready_i,
  output logic              busy_o,
  output logic              flush_done_o,
  output logic [DROP_W-1:0] drop_cnt_o,
  output logic [15:0]       pull_cnt_o
);

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StFlush
  } state_e;

  state_e             state_q, state_d;
  logic               valid_q, valid_d;
  logic [WIDTH-1:0]   data_q, data_d;
  logic [DROP_W-1:0]  drop_q, drop_d;
  logic               free;
  logic               flush_start;

  // Output stage can take a new entry when empty or being drained this cycle.
  assign free = ~valid_q | ready_i;

  // FSM next state and combinational strobes.
  always_comb begin
    state_d      = state_q;
    pull_o       = 1'b0;
    busy_o       = 1'b0;
    flush_done_o = 1'b0;
    flush_start  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (flush_i) begin
          state_d     = StFlush;
          flush_start = 1'b1;
        end else if (enable_i) begin
          state_d = StRun;
        end
      end
      StRun: begin
        pull_o = head_valid_i & free;
        if (flush_i) begin
          state_d     = StFlush;
          flush_start = 1'b1;
        end else if (!enable_i) begin
          state_d = StIdle;
        end
      end
      StFlush: begin
        busy_o = 1'b1;
        pull_o = head_valid_i;
        if (!head_valid_i) begin
          state_d      = StIdle;
          flush_done_o = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Output stage: only pulls made while running load data; flushed entries
  // are popped but never presented.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (pull_o && (state_q == StRun)) begin
      valid_d = 1'b1;
      data_d  = head_value_i;
    end else if (valid_q && ready_i) begin
      valid_d = 1'b0;
    end
  end

  // Discard counter: cleared on flush entry, saturating increment per flush pull.
  always_comb begin
    drop_d = drop_q;
    if (flush_start) begin
      drop_d = '0;
    end else if ((state_q == StFlush) && pull_o && (drop_q != {DROP_W{1'b1}})) begin
      drop_d = drop_q + {{(DROP_W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      state_q <= StIdle;
      valid_q <= 1'b0;
      data_q  <= '0;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      drop_q  <= drop_d;
    end
  end

  assign valid_o    = valid_q;
  assign data_o     = data_q;
  assign drop_cnt_o = drop_q;

`ifdef STATUS_VALUE_PULL_CNT_EN
  logic [15:0] pull_cnt_q;

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      pull_cnt_q <= 16'd0;
    end else if (valid_q && ready_i) begin
      pull_cnt_q <= pull_cnt_q + 16'd1;
    end
  end

  assign pull_cnt_o = pull_cnt_q;
`else
  assign pull_cnt_o = 16'd0;
`endif

endmodule

// File: tb/tb_status_value_pull_ctrl.sv
// Testbench for status_value_pull_ctrl. A queue models the status value vector;
// values that should be delivered are pushed onto a scoreboard when loaded and
// popped/compared on every observed valid_o & ready_i transfer.

module tb_status_value_pull_ctrl;
  localparam int unsigned W = 1;

  logic          clk = 1'b0;
  logic          arstn;
  logic          enable;
  logic          flush;
  logic          head_valid;
  logic [W-1:0]  head_value;
  logic          ready;
  logic          pull_o, valid_o, busy_o, flush_done_o;
  logic [W-1:0]  data_o;
  logic [7:0]    drop_cnt_o;
  logic [15:0]   pull_cnt_o;
  // Second instance with a narrow discard counter, sharing all inputs.
  logic          s_pull_o, s_valid_o, s_busy_o, s_flush_done_o;
  logic [W-1:0]  s_data_o;
  logic [1:0]    s_drop_cnt_o;
  logic [15:0]   s_pull_cnt_o;

  logic [W-1:0]  vec[$];
  logic [W-1:0]  sb[$];
  int            checks = 0;
  int            errors = 0;

`ifdef STATUS_VALUE_PULL_CNT_EN
  localparam logic [15:0] ExpCnt = 16'd3;
`else
  localparam logic [15:0] ExpCnt = 16'd0;
`endif

  always #5 clk = ~clk;

  status_value_pull_ctrl #(.WIDTH(W), .DROP_W(8)) u_dut (
    .clk_i(clk), .arstn_i(arstn), .enable_i(enable), .flush_i(flush),
    .head_valid_i(head_valid), .head_value_i(head_value), .pull_o(pull_o),
    .data_o(data_o), .valid_o(valid_o), .ready_i(ready), .busy_o(busy_o),
    .flush_done_o(flush_done_o), .drop_cnt_o(drop_cnt_o), .pull_cnt_o(pull_cnt_o)
  );

  status_value_pull_ctrl #(.WIDTH(W), .DROP_W(2)) u_dut_sat (
    .clk_i(clk), .arstn_i(arstn), .enable_i(enable), .flush_i(flush),
    .head_valid_i(head_valid), .head_value_i(head_value), .pull_o(s_pull_o),
    .data_o(s_data_o), .valid_o(s_valid_o), .ready_i(ready), .busy_o(s_busy_o),
    .flush_done_o(s_flush_done_o), .drop_cnt_o(s_drop_cnt_o),
    .pull_cnt_o(s_pull_cnt_o)
  );

  function void upd_head();
    head_valid = (vec.size() != 0);
    head_value = (vec.size() != 0) ? vec[0] : '0;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((sb.size() != 0 || vec.size() != 0) && n < 60) begin
      step();
      n++;
    end
    checks++;
    if (sb.size() != 0 || vec.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: got %0d pending entries, required 0", sb.size() + vec.size());
    end
    step();
  endtask

  // Vector model and scoreboard monitor: sample mid-cycle, pop after the edge.
  initial begin : monitor
    logic p, x;
    logic [W-1:0] d, e;
    forever begin
      @(negedge clk);
      p = pull_o;
      x = valid_o & ready;
      d = data_o;
      if (x) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_xfer: got data %0h, required no transfer", d);
        end else begin
          e = sb.pop_front();
          if (d !== e) begin
            errors++;
            $display("FAIL xfer_data: got %0h, required %0h", d, e);
          end
        end
      end
      @(posedge clk);
      #1;
      if (p && vec.size() != 0) void'(vec.pop_front());
      upd_head();
    end
  end

  task automatic test_reset();
    arstn = 1'b0; enable = 1'b0; flush = 1'b0; ready = 1'b1;
    vec.push_back(1'b1); sb.push_back(1'b1); upd_head();
    #12;
    checks++; if (pull_o !== 1'b0) begin errors++; $display("FAIL rst_pull: got %b, required 0", pull_o); end
    checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b, required 0", valid_o); end
    checks++; if (data_o !== '0) begin errors++; $display("FAIL rst_data: got %h, required 0", data_o); end
    checks++; if (drop_cnt_o !== 8'd0) begin errors++; $display("FAIL rst_drop: got %0d, required 0", drop_cnt_o); end
    checks++; if ({busy_o, flush_done_o} !== 2'b00) begin errors++; $display("FAIL rst_busy_done: got %b, required 00", {busy_o, flush_done_o}); end
    checks++; if (pull_cnt_o !== 16'd0) begin errors++; $display("FAIL rst_pull_cnt: got %0d, required 0", pull_cnt_o); end
    step(); arstn = 1'b1;
    step(); step();
    @(negedge clk);
    checks++; if (pull_o !== 1'b0) begin errors++; $display("FAIL idle_pull: got %b, required 0", pull_o); end
    step(); enable = 1'b1;
    @(negedge clk);
    checks++; if (pull_o !== 1'b0) begin errors++; $display("FAIL enable_same_cycle_pull: got %b, required 0", pull_o); end
    @(negedge clk);
    checks++; if (pull_o !== 1'b1) begin errors++; $display("FAIL enable_next_cycle_pull: got %b, required 1", pull_o); end
    wait_drain();
  endtask

  task automatic test_stream();
    logic [W-1:0] vals [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
    step();
    for (int i = 0; i < 4; i++) begin vec.push_back(vals[i]); sb.push_back(vals[i]); end
    upd_head();
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      checks++;
      if (pull_o !== (k < 4)) begin errors++; $display("FAIL stream_pull[%0d]: got %b, required %b", k, pull_o, k < 4); end
      checks++;
      if (valid_o !== (k >= 1 && k <= 4)) begin errors++; $display("FAIL stream_valid[%0d]: got %b, required %b", k, valid_o, (k >= 1 && k <= 4)); end
      if (k >= 1 && k <= 4) begin
        checks++;
        if (data_o !== vals[k-1]) begin errors++; $display("FAIL stream_data[%0d]: got %h, required %h", k, data_o, vals[k-1]); end
      end
    end
    wait_drain();
  endtask

  task automatic test_backpressure();
    step(); ready = 1'b0;
    vec.push_back(1'b1); sb.push_back(1'b1);
    vec.push_back(1'b0); sb.push_back(1'b0);
    upd_head();
    @(negedge clk);
    checks++; if (pull_o !== 1'b1) begin errors++; $display("FAIL bp_first_pull: got %b, required 1", pull_o); end
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      checks++;
      if ({pull_o, valid_o, data_o} !== {1'b0, 1'b1, 1'b1}) begin
        errors++; $display("FAIL bp_hold[%0d]: got pull=%b valid=%b data=%h, required pull=0 valid=1 data=1", k, pull_o, valid_o, data_o);
      end
    end
    step(); ready = 1'b1;
    @(negedge clk);
    checks++; if ({pull_o, valid_o, data_o} !== {1'b1, 1'b1, 1'b1}) begin
      errors++; $display("FAIL bp_release: got pull=%b valid=%b data=%h, required pull=1 valid=1 data=1", pull_o, valid_o, data_o);
    end
    @(negedge clk);
    checks++; if ({valid_o, data_o} !== {1'b1, 1'b0}) begin
      errors++; $display("FAIL bp_next: got valid=%b data=%h, required valid=1 data=0", valid_o, data_o);
    end
    wait_drain();
  endtask

  task automatic test_flush();
    step(); enable = 1'b0;
    step(); step();
    for (int i = 0; i < 6; i++) vec.push_back(W'(i % 2));
    upd_head(); flush = 1'b1;
    step(); flush = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      checks++;
      if ({pull_o, valid_o, busy_o} !== 3'b101) begin
        errors++; $display("FAIL flush_cycle[%0d]: got pull=%b valid=%b busy=%b, required 1 0 1", k, pull_o, valid_o, busy_o);
      end
    end
    @(negedge clk);
    checks++; if ({flush_done_o, pull_o} !== 2'b10) begin errors++; $display("FAIL flush_done: got done=%b pull=%b, required done=1 pull=0", flush_done_o, pull_o); end
    checks++; if (drop_cnt_o !== 8'd6) begin errors++; $display("FAIL flush_drop: got %0d, required 6", drop_cnt_o); end
    checks++; if (s_drop_cnt_o !== 2'd3) begin errors++; $display("FAIL flush_drop_sat: got %0d, required 3", s_drop_cnt_o); end
    @(negedge clk);
    checks++; if ({busy_o, flush_done_o} !== 2'b00) begin errors++; $display("FAIL flush_back_idle: got busy=%b done=%b, required 0 0", busy_o, flush_done_o); end
  endtask

  task automatic test_empty_flush();
    step(); flush = 1'b1;
    @(negedge clk);
    checks++; if (flush_done_o !== 1'b0) begin errors++; $display("FAIL eflush_early_done: got %b, required 0", flush_done_o); end
    step(); flush = 1'b0;
    @(negedge clk);
    checks++; if ({flush_done_o, busy_o} !== 2'b11) begin errors++; $display("FAIL eflush_done: got done=%b busy=%b, required 1 1", flush_done_o, busy_o); end
    checks++; if (drop_cnt_o !== 8'd0) begin errors++; $display("FAIL eflush_drop: got %0d, required 0", drop_cnt_o); end
    @(negedge clk);
    checks++; if ({flush_done_o, busy_o} !== 2'b00) begin errors++; $display("FAIL eflush_after: got done=%b busy=%b, required 0 0", flush_done_o, busy_o); end
  endtask

  task automatic test_flush_keeps_presented();
    step(); ready = 1'b0; enable = 1'b1;
    vec.push_back(1'b1); sb.push_back(1'b1); upd_head();
    step(); step();
    @(negedge clk);
    checks++; if ({valid_o, data_o} !== {1'b1, 1'b1}) begin errors++; $display("FAIL keep_presented: got valid=%b data=%h, required 1 1", valid_o, data_o); end
    step();
    vec.push_back(1'b0); vec.push_back(1'b0); upd_head();
    flush = 1'b1; enable = 1'b0;
    @(negedge clk);
    checks++; if (pull_o !== 1'b0) begin errors++; $display("FAIL keep_no_pull_full: got %b, required 0", pull_o); end
    step(); flush = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      checks++;
      if ({pull_o, valid_o, data_o} !== {1'b1, 1'b1, 1'b1}) begin
        errors++; $display("FAIL keep_flush[%0d]: got pull=%b valid=%b data=%h, required 1 1 1", k, pull_o, valid_o, data_o);
      end
    end
    @(negedge clk);
    checks++; if ({flush_done_o, drop_cnt_o} !== {1'b1, 8'd2}) begin errors++; $display("FAIL keep_done: got done=%b drop=%0d, required done=1 drop=2", flush_done_o, drop_cnt_o); end
    step(); ready = 1'b1;
    wait_drain();
    @(negedge clk);
    checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL keep_after: got valid=%b, required 0", valid_o); end
  endtask

  task automatic test_reset_mid_flush();
    step();
    for (int i = 0; i < 4; i++) vec.push_back(1'b1);
    upd_head(); flush = 1'b1;
    step(); flush = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #2 arstn = 1'b0;
    #1;
    checks++; if ({busy_o, pull_o, valid_o, flush_done_o} !== 4'b0000) begin
      errors++; $display("FAIL mid_rst_ctrl: got busy=%b pull=%b valid=%b done=%b, required 0 0 0 0", busy_o, pull_o, valid_o, flush_done_o);
    end
    checks++; if (drop_cnt_o !== 8'd0) begin errors++; $display("FAIL mid_rst_drop: got %0d, required 0", drop_cnt_o); end
    checks++; if (pull_cnt_o !== 16'd0) begin errors++; $display("FAIL mid_rst_pull_cnt: got %0d, required 0", pull_cnt_o); end
    @(posedge clk);
    #2 vec.delete(); sb.delete(); upd_head();
    step(); arstn = 1'b1;
  endtask

  task automatic test_pull_cnt();
    step(); ready = 1'b1; enable = 1'b1;
    for (int i = 0; i < 3; i++) begin vec.push_back(W'(i % 2)); sb.push_back(W'(i % 2)); end
    upd_head();
    wait_drain();
    @(negedge clk);
    checks++; if (pull_cnt_o !== ExpCnt) begin errors++; $display("FAIL pull_cnt: got %0d, required %0d", pull_cnt_o, ExpCnt); end
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_flush();
    test_empty_flush();
    test_flush_keeps_presented();
    test_reset_mid_flush();
    test_pull_cnt();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
